// File: rtl/ky32_pkg.sv
// Shared constants and skid-buffer state encoding for the KY32 write-select decoder.
package ky32_pkg;

    localparam int SEL_W_MIN = 1;
    localparam int SEL_W_MAX = 6;
    localparam int ZERO_IDX  = 0;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_t;

endpackage

// File: rtl/ky32_onehot_dec.sv
// Combinational index-to-one-hot decoder with enable and optional register-0 suppression.
module ky32_onehot_dec
    import ky32_pkg::*;
#(
    parameter int SEL_W = 3
) (
    input  logic [SEL_W-1:0]      idx,
    input  logic                  ena,
    input  logic                  zsup,
    output logic [2**SEL_W-1:0]   sel
);

    always_comb begin
        sel = '0;
        if (ena && !(zsup && (idx == SEL_W'(ZERO_IDX)))) begin
            sel[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/ky32_wsel_decoder.sv
// KY32 register-file write-port decoder: one-hot select plus data, registered behind a 2-entry skid buffer.
module ky32_wsel_decoder
    import ky32_pkg::*;
#(
    parameter int SEL_W         = 3,
    parameter int DATA_W        = 32,
    parameter bit ZERO_SUPPRESS = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_ena,
    input  logic [SEL_W-1:0]      in_idx,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2**SEL_W-1:0]   out_sel,
    output logic [DATA_W-1:0]     out_data,
    output logic [15:0]           supp_cnt
);

    localparam int SEL_N = 2**SEL_W;

    if (SEL_W < SEL_W_MIN || SEL_W > SEL_W_MAX) begin : g_bad_sel_w
        $error("ky32_wsel_decoder: SEL_W out of legal range");
    end

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [SEL_N-1:0]  w_sel_p0;
    skid_state_t       r_state;
    skid_state_t       w_next_state;
    logic              r_in_ready;
    logic              w_accept;
    logic              w_load_out;
    logic              w_load_skid;
    logic              w_skid_to_out;
    logic [15:0]       r_supp_cnt;
    logic [SEL_N-1:0]  r_out_sel_p1;
    logic [DATA_W-1:0] r_out_data_p1;
    logic [SEL_N-1:0]  r_skid_sel_p1;
    logic [DATA_W-1:0] r_skid_data_p1;

    // Stage p0: decode the incoming index
    ky32_onehot_dec #(
        .SEL_W (SEL_W)
    ) u_dec (
        .idx  (in_idx),
        .ena  (in_ena),
        .zsup (ZERO_SUPPRESS),
        .sel  (w_sel_p0)
    );

    assign w_accept = in_valid && r_in_ready;

    always_comb begin
        w_next_state  = r_state;
        w_load_out    = 1'b0;
        w_load_skid   = 1'b0;
        w_skid_to_out = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_accept) begin
                    w_load_out   = 1'b1;
                    w_next_state = ONE;
                end
            end
            ONE: begin
                if (w_accept && out_ready) begin
                    w_load_out = 1'b1;
                end else if (w_accept) begin
                    w_load_skid  = 1'b1;
                    w_next_state = TWO;
                end else if (out_ready) begin
                    w_next_state = EMPTY;
                end
            end
            TWO: begin
                if (out_ready) begin
                    w_skid_to_out = 1'b1;
                    w_next_state  = ONE;
                end
            end
            default: w_next_state = EMPTY;
        endcase
    end

    // in_ready is registered from the next state so it never depends on out_ready combinationally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= EMPTY;
            r_in_ready <= 1'b0;
            r_supp_cnt <= '0;
        end else begin
            r_state    <= w_next_state;
            r_in_ready <= (w_next_state != TWO);
            if (w_accept && (w_sel_p0 == '0)) begin
                r_supp_cnt <= sat_inc16(r_supp_cnt);
            end
        end
    end

    // Stage p1: output register and skid entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_sel_p1   <= '0;
            r_out_data_p1  <= '0;
            r_skid_sel_p1  <= '0;
            r_skid_data_p1 <= '0;
        end else begin
            if (w_load_out) begin
                r_out_sel_p1  <= w_sel_p0;
                r_out_data_p1 <= in_data;
            end else if (w_skid_to_out) begin
                r_out_sel_p1  <= r_skid_sel_p1;
                r_out_data_p1 <= r_skid_data_p1;
            end
            if (w_load_skid) begin
                r_skid_sel_p1  <= w_sel_p0;
                r_skid_data_p1 <= in_data;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = (r_state != EMPTY);
    assign out_sel   = r_out_sel_p1;
    assign out_data  = r_out_data_p1;
    assign supp_cnt  = r_supp_cnt;

endmodule

// File: tb/tb_ky32_wsel_decoder.sv
// Self-checking bench for ky32_wsel_decoder: directed scenarios plus a randomized scoreboard run.
module tb_ky32_wsel_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ena = 1'b0;
    logic [3:0]  in_idx = '0;
    logic [31:0] in_data = '0;
    logic        out_ready = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_sel;
    logic [31:0] out_data;
    logic [15:0] supp_cnt;

    logic        z_in_ready;
    logic        z_out_valid;
    logic [7:0]  z_out_sel;
    logic [31:0] z_out_data;
    logic [15:0] z_supp_cnt;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] sel;
        logic [31:0] data;
    } beat_t;

    always #5 clk = ~clk;

    ky32_wsel_decoder #(
        .SEL_W(4), .DATA_W(32), .ZERO_SUPPRESS(1'b1)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_ena(in_ena),
        .in_idx(in_idx), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sel(out_sel), .out_data(out_data), .supp_cnt(supp_cnt)
    );

    ky32_wsel_decoder #(
        .SEL_W(3), .DATA_W(32), .ZERO_SUPPRESS(1'b0)
    ) dut_z (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(z_in_ready), .in_ena(in_ena),
        .in_idx(in_idx[2:0]), .in_data(in_data),
        .out_valid(z_out_valid), .out_ready(out_ready),
        .out_sel(z_out_sel), .out_data(z_out_data), .supp_cnt(z_supp_cnt)
    );

    // Reference decode: bit i is set only for an enabled write to a register other than x0.
    function automatic logic [15:0] ref_sel(input logic ena, input logic [3:0] idx);
        logic [15:0] s;
        s = '0;
        for (int i = 1; i < 16; i++) begin
            if (ena && (int'(idx) == i)) s[i] = 1'b1;
        end
        return s;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0; in_ena = 1'b0; out_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        total++;
        if (out_valid !== 1'b0 || out_sel !== 16'h0 || out_data !== 32'h0) begin
            bad++;
            $display("FAIL reset_outputs: valid=%b sel=%h data=%h required 0/0000/00000000", out_valid, out_sel, out_data);
        end
        total++;
        if (supp_cnt !== 16'h0) begin
            bad++;
            $display("FAIL reset_supp_cnt: got %h required 0000", supp_cnt);
        end
        rst = 1'b0;
        step();
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready: got %b required 1", in_ready);
        end
    endtask

    task automatic test_basic();
        in_valid = 1'b1; in_ena = 1'b1; in_idx = 4'd5; in_data = 32'hDEADBEEF; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_sel !== 16'h0020 || out_data !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL basic_decode: valid=%b sel=%h data=%h required 1/0020/deadbeef", out_valid, out_sel, out_data);
        end
        total++;
        if (supp_cnt !== 16'h0) begin
            bad++;
            $display("FAIL basic_supp_cnt: got %h required 0000", supp_cnt);
        end
        step();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_drain: out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_zero_idx();
        in_valid = 1'b1; in_ena = 1'b1; in_idx = 4'd0; in_data = 32'h0000_1234; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_sel !== 16'h0000) begin
            bad++;
            $display("FAIL zero_suppressed: valid=%b sel=%h required 1/0000", out_valid, out_sel);
        end
        total++;
        if (supp_cnt !== 16'd1) begin
            bad++;
            $display("FAIL zero_supp_cnt: got %h required 0001", supp_cnt);
        end
        total++;
        if (z_out_valid !== 1'b1 || z_out_sel !== 8'h01 || z_out_data !== 32'h0000_1234) begin
            bad++;
            $display("FAIL zero_unsuppressed: valid=%b sel=%h data=%h required 1/01/00001234", z_out_valid, z_out_sel, z_out_data);
        end
        total++;
        if (z_supp_cnt !== 16'd0) begin
            bad++;
            $display("FAIL zero_unsupp_cnt: got %h required 0000", z_supp_cnt);
        end
        step();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0; in_valid = 1'b1; in_ena = 1'b1;
        in_idx = 4'd1; in_data = 32'hA1;
        step();
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_ready_after_1: got %b required 1", in_ready);
        end
        in_idx = 4'd2; in_data = 32'hA2;
        step();
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL b2b_ready_after_2: got %b required 0", in_ready);
        end
        in_idx = 4'd3; in_data = 32'hA3;
        step(); step();
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_sel !== 16'h0002 || out_data !== 32'hA1) begin
            bad++;
            $display("FAIL b2b_hold: ready=%b valid=%b sel=%h data=%h required 0/1/0002/000000a1", in_ready, out_valid, out_sel, out_data);
        end
        out_ready = 1'b1;
        step();
        total++;
        if (out_valid !== 1'b1 || out_sel !== 16'h0004 || out_data !== 32'hA2 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_second: valid=%b sel=%h data=%h ready=%b required 1/0004/000000a2/1", out_valid, out_sel, out_data, in_ready);
        end
        step();
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_sel !== 16'h0008 || out_data !== 32'hA3) begin
            bad++;
            $display("FAIL b2b_third: valid=%b sel=%h data=%h required 1/0008/000000a3", out_valid, out_sel, out_data);
        end
        step();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_no_duplicate: out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_disable_sat();
        do_reset();
        out_ready = 1'b1; in_ena = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_idx = 4'($urandom_range(1, 15));
            in_data = $urandom;
            step();
            total++;
            if (out_valid !== 1'b1 || out_sel !== 16'h0) begin
                bad++;
                $display("FAIL disabled_beat%0d: valid=%b sel=%h required 1/0000", k, out_valid, out_sel);
            end
        end
        in_valid = 1'b0;
        step();
        total++;
        if (supp_cnt !== 16'd3) begin
            bad++;
            $display("FAIL disabled_cnt: got %h required 0003", supp_cnt);
        end
        force dut.r_supp_cnt = 16'hFFFE;
        step();
        release dut.r_supp_cnt;
        total++;
        if (supp_cnt !== 16'hFFFE) begin
            bad++;
            $display("FAIL preset_cnt: got %h required fffe", supp_cnt);
        end
        in_valid = 1'b1;
        step(); step(); step();
        in_valid = 1'b0;
        step();
        total++;
        if (supp_cnt !== 16'hFFFF) begin
            bad++;
            $display("FAIL saturate_cnt: got %h required ffff", supp_cnt);
        end
    endtask

    task automatic test_reset_in_two();
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1; in_ena = 1'b1;
        in_idx = 4'd6; in_data = 32'h6666_6666;
        step();
        in_idx = 4'd7; in_data = 32'h7777_7777;
        step();
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL two_setup: valid=%b ready=%b required 1/0", out_valid, in_ready);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || out_sel !== 16'h0 || out_data !== 32'h0) begin
            bad++;
            $display("FAIL async_clear: valid=%b sel=%h data=%h required 0/0000/00000000", out_valid, out_sel, out_data);
        end
        step();
        rst = 1'b0;
        step();
        out_ready = 1'b1; in_valid = 1'b1; in_idx = 4'd9; in_data = 32'hF00D_CAFE;
        step();
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_sel !== 16'h0200 || out_data !== 32'hF00D_CAFE) begin
            bad++;
            $display("FAIL post_reset_fresh: valid=%b sel=%h data=%h required 1/0200/f00dcafe", out_valid, out_sel, out_data);
        end
        step();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_stale: out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_random();
        beat_t       q[$];
        beat_t       b;
        int          accepted;
        int          cyc;
        logic [15:0] exp_supp;
        logic        prev_stall;
        logic [15:0] hold_sel;
        logic [31:0] hold_data;
        logic        acc;
        logic        drn;
        accepted = 0; cyc = 0; exp_supp = '0; prev_stall = 1'b0;
        hold_sel = '0; hold_data = '0;
        do_reset();
        while (accepted < 10000 && cyc < 60000) begin
            if (prev_stall) begin
                total++;
                if (out_valid !== 1'b1 || out_sel !== hold_sel || out_data !== hold_data) begin
                    bad++;
                    $display("FAIL stall_stable: valid=%b sel=%h data=%h required 1/%h/%h", out_valid, out_sel, out_data, hold_sel, hold_data);
                end
            end
            in_valid  = ($urandom_range(0, 9) < 7);
            in_ena    = ($urandom_range(0, 9) < 8);
            in_idx    = 4'($urandom_range(0, 15));
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 9) < 7);
            total++;
            if ($countones(out_sel) > 1) begin
                bad++;
                $display("FAIL onehot: sel=%h required popcount<=1", out_sel);
            end
            acc = in_valid && in_ready;
            drn = out_valid && out_ready;
            if (drn) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_extra_beat: sel=%h data=%h required no beat", out_sel, out_data);
                end else begin
                    b = q.pop_front();
                    if (out_sel !== b.sel || out_data !== b.data) begin
                        bad++;
                        $display("FAIL sb_order: sel=%h data=%h required %h/%h", out_sel, out_data, b.sel, b.data);
                    end
                end
            end
            if (acc) begin
                b.sel  = ref_sel(in_ena, in_idx);
                b.data = in_data;
                q.push_back(b);
                accepted++;
                if (b.sel == '0 && exp_supp != 16'hFFFF) exp_supp++;
            end
            prev_stall = out_valid && !out_ready;
            hold_sel   = out_sel;
            hold_data  = out_data;
            step();
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        if (accepted < 10000) begin
            total++; bad++;
            $display("FAIL random_budget: accepted=%0d required 10000", accepted);
        end
        for (int k = 0; k < 8 && q.size() > 0; k++) begin
            if (out_valid) begin
                total++;
                b = q.pop_front();
                if (out_sel !== b.sel || out_data !== b.data) begin
                    bad++;
                    $display("FAIL sb_drain: sel=%h data=%h required %h/%h", out_sel, out_data, b.sel, b.data);
                end
            end
            step();
        end
        total++;
        if (q.size() != 0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL sb_empty: pending=%0d out_valid=%b required 0/0", q.size(), out_valid);
        end
        total++;
        if (supp_cnt !== exp_supp) begin
            bad++;
            $display("FAIL random_supp_cnt: got %h required %h", supp_cnt, exp_supp);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_idx();
        test_back_to_back();
        test_disable_sat();
        test_reset_in_two();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
